// File: rtl/sm_imem_loader.sv
// Byte-stream instruction-memory loader: packs a length-prefixed little-endian byte
// stream into 32-bit words, writes them to the instruction RAM and holds the core in reset meanwhile.
module sm_imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] imWrAddr,
    output logic [31:0]           imWrData,
    output logic                  imWe,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [15:0] CAPACITY = 16'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           buf_q, buf_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic [15:0]           len_full;
    logic                  last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign accept    = in_valid && in_ready;
    assign len_full  = {in_data, len_lo_q};
    assign last_word = (({1'b0, word_cnt_q} + (ADDR_WIDTH+1)'(1)) == len_q);

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        cpu_hold   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LEN0;
                    err_d   = 1'b0;
                end
            end
            LEN0: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    len_lo_d = in_data;
                    state_d  = LEN1;
                end
            end
            LEN1: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if (len_full > CAPACITY) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = DATA;
                        len_d      = len_full[ADDR_WIDTH:0];
                        word_cnt_d = '0;
                        byte_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    buf_d      = {in_data, buf_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        // Word complete: register the RAM write for the next cycle.
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q;
                        wdata_d    = {in_data, buf_q};
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (last_word) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                cpu_hold = 1'b1;
                busy     = 1'b1;
                done     = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                cpu_hold = 1'b1;
                if (load_start) begin
                    state_d = LEN0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imWe     = we_q;
    assign imWrAddr = addr_q;
    assign imWrData = wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Directed bench for sm_imem_loader: drives byte streams and checks RAM writes,
// handshake, hold/busy/done/err behaviour against hand-computed values.
module tb_sm_imem_loader;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] imWrAddr;
    logic [31:0]   imWrData;
    logic          imWe;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;
    int done_cnt = 0;
    logic last_done_we = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    sm_imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imWrAddr  (imWrAddr),
        .imWrData  (imWrData),
        .imWe      (imWe),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Passive write/done logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (imWe) begin
            wr_addr_q.push_back(32'(imWrAddr));
            wr_data_q.push_back(imWrData);
        end
        if (done) begin
            done_cnt++;
            last_done_we = imWe;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
        last_done_we = 1'b0;
        stall_cnt = 0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Offer one byte and return at #1 after the edge that accepted it.
    task automatic send(input logic [7:0] b, input bit throttle);
        bit got_it;
        if (throttle) begin
            in_valid = 1'b0;
            tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        got_it   = 1'b0;
        for (int i = 0; i < 20 && !got_it; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got_it = 1'b1;
                tick();
            end else begin
                stall_cnt++;
            end
        end
        in_valid = 1'b0;
        if (!got_it) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_flags"}, {26'd0, in_ready, imWe, cpu_hold, busy, done, err}, 32'd0);
        chk({tag, "_addr"}, 32'(imWrAddr), 32'd0);
        chk({tag, "_data"}, imWrData, 32'd0);
    endtask

    task automatic two_word_load(input bit throttle, input string tag);
        logic [7:0] bytes [10];
        bytes = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h24, 8'h03, 8'h00, 8'h03, 8'h24};
        clear_log();
        pulse_start();
        chk({tag, "_hold_after_start"}, {31'd0, cpu_hold}, 32'd1);
        chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 10; i++) send(bytes[i], throttle);
        chk({tag, "_final_we"}, {31'd0, imWe}, 32'd1);
        chk({tag, "_final_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_final_addr"}, 32'(imWrAddr), 32'd1);
        chk({tag, "_hold_in_done"}, {31'd0, cpu_hold}, 32'd1);
        tick();
        chk({tag, "_after_done"}, {28'd0, cpu_hold, busy, done, imWe}, 32'd0);
        chk({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            chk({tag, "_w0_addr"}, wr_addr_q[0], 32'd0);
            chk({tag, "_w0_data"}, wr_data_q[0], 32'h24020001);
            chk({tag, "_w1_addr"}, wr_addr_q[1], 32'd1);
            chk({tag, "_w1_data"}, wr_data_q[1], 32'h24030003);
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_with_we"}, {31'd0, last_done_we}, 32'd1);
        chk({tag, "_stalls"}, 32'(stall_cnt), 32'd0);
    endtask

    initial begin
        int errs;
        // Reset
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        two_word_load(1'b0, "normal");
        two_word_load(1'b1, "throttle");

        // Zero length
        clear_log();
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_we", {31'd0, imWe}, 32'd0);
        tick();
        chk("zero_hold_released", {30'd0, cpu_hold, busy}, 32'd0);
        chk("zero_nwrites", 32'(wr_addr_q.size()), 32'd0);

        // Overflow: N=65
        clear_log();
        pulse_start();
        send(8'h41, 1'b0);
        send(8'h00, 1'b0);
        chk("ovf_flags", {28'd0, err, cpu_hold, in_ready, busy}, 32'b1100);
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("ovf_sticky", {29'd0, err, cpu_hold, in_ready}, 32'b110);
        chk("ovf_nwrites", 32'(wr_addr_q.size()), 32'd0);
        pulse_start();
        chk("ovf_restart", {29'd0, err, in_ready, busy}, 32'b011);

        // Full capacity continues from LEN0 entered above: N=64, word i = i
        send(8'h40, 1'b0);
        send(8'h00, 1'b0);
        for (int w = 0; w < 64; w++) begin
            send(8'(w), 1'b0);
            send(8'h00, 1'b0);
            send(8'h00, 1'b0);
            send(8'h00, 1'b0);
        end
        chk("full_done", {30'd0, done, imWe}, 32'b11);
        chk("full_last_addr", 32'(imWrAddr), 32'd63);
        tick();
        chk("full_nwrites", 32'(wr_addr_q.size()), 32'd64);
        errs = 0;
        for (int w = 0; w < wr_addr_q.size(); w++) begin
            if (wr_addr_q[w] != 32'(w) || wr_data_q[w] != 32'(w)) errs++;
        end
        chk("full_contents_bad", 32'(errs), 32'd0);
        chk("full_released", {31'd0, cpu_hold}, 32'd0);

        // Reset mid-load, then a clean one-word load with a stray load_start
        clear_log();
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b0;
        chk("midrst_nwrites", 32'(wr_addr_q.size()), 32'd0);
        pulse_start();
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'hEF, 1'b0);
        load_start = 1'b1;
        send(8'hBE, 1'b0);
        load_start = 1'b0;
        chk("stray_start_ignored", {30'd0, busy, in_ready}, 32'b11);
        send(8'hAD, 1'b0);
        send(8'hDE, 1'b0);
        chk("reload_done", {30'd0, done, imWe}, 32'b11);
        tick();
        chk("reload_nwrites", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            chk("reload_addr", wr_addr_q[0], 32'd0);
            chk("reload_data", wr_data_q[0], 32'hDEADBEEF);
        end
        chk("reload_released", {31'd0, cpu_hold}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
